// File: rtl/layer_act_pkg.sv
// Shared encodings and default sizing for the layer activation ping-pong buffer.
package layer_act_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_FRAME_LEN = 32768;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_OFFER = 2'd1,
        R_BUSY  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/act_bank_ram.sv
// One activation bank: simple dual-port RAM with a registered, enable-held read port.
module act_bank_ram
    import layer_act_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is reset; stored words survive a reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else if (i_re) begin
            o_q <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/layer_act_pingpong.sv
// Activation frame buffer: AXI-stream writer fills banks, PE reads a bank after a sync handshake.
// Define ACT_BUF_PINGPONG_EN for two banks; otherwise one bank and the writer waits for release.
module layer_act_pingpong
    import layer_act_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] act_tdata,
    input  logic              act_tvalid,
    output logic              act_tready,
    output logic              sync_vld,
    input  logic              sync_ack,
    output logic              sync_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ce,
    output logic [DATA_W-1:0] rd_q,
    input  logic              rd_release,
    output logic [1:0]        bank_full
);

`ifdef ACT_BUF_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    wr_state_e         r_wstate;
    logic              r_tready;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_bank;
    logic [1:0]        r_full;
    rd_state_e         r_rstate;
    logic              r_sync_vld;
    logic              r_rd_bank;
    logic              r_rd_sel;

    logic              w_accept;
    logic              w_last;
    logic              w_release;
    logic              w_rd_en;
    logic [1:0]        w_full_nxt;
    logic              w_wr_bank_nxt;
    logic [DATA_W-1:0] w_q [2];

    assign w_accept  = act_tvalid && r_tready && (r_wstate == W_FILL);
    assign w_last    = w_accept && (r_wr_addr == LAST_ADDR);
    assign w_release = rd_release && (r_rstate == R_BUSY);
    assign w_rd_en   = rd_ce && (r_rstate == R_BUSY);

    // Completion and release touch different banks, so both apply in one cycle.
    always_comb begin
        w_full_nxt    = r_full;
        w_wr_bank_nxt = r_wr_bank;
        if (w_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt         = (NBANK == 2) ? ~r_wr_bank : 1'b0;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (NBANK == 1) begin
            w_full_nxt[1] = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Ready is registered from the next-cycle bank status so it is valid right after each edge.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_wstate  <= W_FILL;
            r_tready  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_bank <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_addr <= w_last ? '0 : r_wr_addr + ADDR_W'(1);
            end
            r_wr_bank <= w_wr_bank_nxt;
            r_tready  <= ~w_full_nxt[w_wr_bank_nxt];
            r_wstate  <= w_full_nxt[w_wr_bank_nxt] ? W_STALL : W_FILL;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rstate   <= R_IDLE;
            r_sync_vld <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_rstate   <= R_OFFER;
                        r_sync_vld <= 1'b1;
                    end
                end
                R_OFFER: begin
                    if (sync_ack) begin
                        r_rstate   <= R_BUSY;
                        r_sync_vld <= 1'b0;
                    end
                end
                R_BUSY: begin
                    if (rd_release) begin
                        r_rstate  <= R_IDLE;
                        r_rd_bank <= (NBANK == 2) ? ~r_rd_bank : 1'b0;
                    end
                end
                default: begin
                    r_rstate   <= R_IDLE;
                    r_sync_vld <= 1'b0;
                end
            endcase
        end
    end

    // Output mux select follows the bank of the last issued read so rd_q holds when idle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd_sel <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_sel <= r_rd_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NBANK) begin : g_ram
            act_bank_ram #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_ram (
                .i_clk   (ap_clk),
                .i_rst   (ap_rst),
                .i_we    (w_accept && (r_wr_bank == 1'(b))),
                .i_waddr (r_wr_addr),
                .i_wdata (act_tdata),
                .i_re    (w_rd_en && (r_rd_bank == 1'(b))),
                .i_raddr (rd_addr),
                .o_q     (w_q[b])
            );
        end else begin : g_tie
            assign w_q[b] = '0;
        end
    end

    assign act_tready = r_tready;
    assign sync_vld   = r_sync_vld;
    assign sync_bank  = (NBANK == 2) ? r_rd_bank : 1'b0;
    assign bank_full  = r_full;
    assign rd_q       = w_q[r_rd_sel];

endmodule

// File: tb/tb_layer_act_pingpong.sv
// Directed bench for layer_act_pingpong (FRAME_LEN=16) with a frame-level reference model.
module tb_layer_act_pingpong;

`ifdef ACT_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] act_tdata;
    logic          act_tvalid;
    logic          act_tready;
    logic          sync_vld;
    logic          sync_ack;
    logic          sync_bank;
    logic [AW-1:0] rd_addr;
    logic          rd_ce;
    logic [DW-1:0] rd_q;
    logic          rd_release;
    logic [1:0]    bank_full;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    layer_act_pingpong #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .ap_clk     (clk),
        .ap_rst     (rst),
        .act_tdata  (act_tdata),
        .act_tvalid (act_tvalid),
        .act_tready (act_tready),
        .sync_vld   (sync_vld),
        .sync_ack   (sync_ack),
        .sync_bank  (sync_bank),
        .rd_addr    (rd_addr),
        .rd_ce      (rd_ce),
        .rd_q       (rd_q),
        .rd_release (rd_release),
        .bank_full  (bank_full)
    );

    // Reference: frames land in banks in order, a full bank is offered, then read until released.
    logic [DW-1:0] mem [2][FL];
    logic [1:0]    m_full;
    logic          m_wbank;
    int            m_waddr;
    logic          m_tready;
    int            m_phase;   // 0 waiting for a frame, 1 offering, 2 PE owns the bank
    logic          m_rbank;
    logic [DW-1:0] m_q;

    always @(posedge clk or posedge rst) begin : model
        logic       acc;
        logic       done;
        logic       rel;
        logic [1:0] fn;
        logic       nwb;
        if (rst) begin
            m_full   <= '0;
            m_wbank  <= 1'b0;
            m_waddr  <= 0;
            m_tready <= 1'b0;
            m_phase  <= 0;
            m_rbank  <= 1'b0;
            m_q      <= '0;
        end else begin
            acc  = act_tvalid && m_tready;
            done = acc && (m_waddr == FL - 1);
            rel  = rd_release && (m_phase == 2);
            fn   = m_full;
            nwb  = m_wbank;
            if (acc) mem[m_wbank][m_waddr] <= act_tdata;
            if (done) begin
                fn[m_wbank] = 1'b1;
                nwb = (NB == 2) ? ~m_wbank : 1'b0;
            end
            if (rel) fn[m_rbank] = 1'b0;
            if (acc) m_waddr <= done ? 0 : m_waddr + 1;
            m_wbank  <= nwb;
            m_full   <= fn;
            m_tready <= ~fn[nwb];
            if (m_phase == 2 && rd_ce) m_q <= mem[m_rbank][rd_addr];
            if (m_phase == 0 && m_full[m_rbank]) m_phase <= 1;
            else if (m_phase == 1 && sync_ack) m_phase <= 2;
            else if (rel) begin
                m_phase <= 0;
                m_rbank <= (NB == 2) ? ~m_rbank : 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired at %0t", nm, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_tready", 32'(act_tready), 32'(m_tready));
            check("cyc_sync_vld", 32'(sync_vld), 32'(m_phase == 1));
            check("cyc_sync_bank", 32'(sync_bank), 32'(m_rbank));
            check("cyc_bank_full", 32'(bank_full), 32'(m_full));
            check("cyc_rd_q", 32'(rd_q), 32'(m_q));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int n = 0;
        act_tvalid = 1'b1;
        act_tdata  = d;
        while (!act_tready && n < 100) begin
            step();
            n++;
        end
        if (n == 100) fail_now("beat_accept");
        step();
    endtask

    task automatic stream(input int start, input int cnt);
        for (int i = 0; i < cnt; i++) send_beat(DW'(start + i));
        act_tvalid = 1'b0;
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!sync_vld && n < 50) begin
            step();
            n++;
        end
        if (n == 50) fail_now("sync_vld_wait");
    endtask

    task automatic handshake();
        sync_ack = 1'b1;
        step();
        sync_ack = 1'b0;
    endtask

    task automatic read_chk(input int a, input logic [DW-1:0] exp);
        rd_ce   = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_ce = 1'b0;
        check("rd_q_lit", 32'(rd_q), 32'(exp));
    endtask

    task automatic release_pulse();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        act_tdata = '0; act_tvalid = 1'b0; sync_ack = 1'b0;
        rd_addr = '0; rd_ce = 1'b0; rd_release = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        step();
        check("rst_tready", 32'(act_tready), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        rst = 1'b0;
        step();
        check("tready_after_rst", 32'(act_tready), 32'd1);

`ifdef ACT_BUF_PINGPONG_EN
        // Single frame with ack tied high.
        sync_ack = 1'b1;
        stream(8'h00, 16);
        check("f0_full", 32'(bank_full), 32'b01);
        check("f0_vld_pre", 32'(sync_vld), 32'd0);
        step();
        check("f0_vld", 32'(sync_vld), 32'd1);
        check("f0_bank", 32'(sync_bank), 32'd0);
        step();
        check("f0_vld_drop", 32'(sync_vld), 32'd0);
        sync_ack = 1'b0;
        read_chk(5, 8'h05);
        step();
        check("rd_q_hold", 32'(rd_q), 32'h05);
        release_pulse();
        check("f0_released", 32'(bank_full), 32'b00);

        // Two frames without release fill both banks and stall the writer.
        stream(8'h20, 32);
        check("stall_tready", 32'(act_tready), 32'd0);
        check("stall_full", 32'(bank_full), 32'b11);
        act_tvalid = 1'b1;
        act_tdata  = 8'h40;
        for (int i = 0; i < 10; i++) begin
            rd_release = (i == 2 || i == 5);
            step();
            check("hold_vld", 32'(sync_vld), 32'd1);
            check("hold_bank", 32'(sync_bank), 32'd1);
            check("hold_full", 32'(bank_full), 32'b11);
        end
        rd_release = 1'b0;
        handshake();
        read_chk(2, 8'h22);
        release_pulse();
        act_tvalid = 1'b0;
        check("resume_tready", 32'(act_tready), 32'd1);
        check("resume_full", 32'(bank_full), 32'b01);
        wait_vld();
        check("fB_bank", 32'(sync_bank), 32'd0);
        handshake();
        read_chk(3, 8'h33);

        // Last beat of the next frame coincides with the release of bank 0.
        stream(8'h40, 15);
        check("coinc_ready", 32'(act_tready), 32'd1);
        act_tvalid = 1'b1;
        act_tdata  = 8'h4F;
        rd_release = 1'b1;
        step();
        act_tvalid = 1'b0;
        rd_release = 1'b0;
        check("coinc_full", 32'(bank_full), 32'b10);
        check("coinc_tready", 32'(act_tready), 32'd1);
        wait_vld();
        check("fC_bank", 32'(sync_bank), 32'd1);
        handshake();
        read_chk(15, 8'h4F);
        read_chk(0, 8'h40);
        release_pulse();
        check("fC_released", 32'(bank_full), 32'b00);
`else
        // One bank: the writer waits for the release between frames.
        stream(8'h00, 16);
        check("sb_tready", 32'(act_tready), 32'd0);
        check("sb_full", 32'(bank_full), 32'b01);
        act_tvalid = 1'b1;
        act_tdata  = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sb_stall", 32'(act_tready), 32'd0);
        end
        wait_vld();
        check("sb_bank0", 32'(sync_bank), 32'd0);
        handshake();
        read_chk(5, 8'h05);
        release_pulse();
        check("sb_resume", 32'(act_tready), 32'd1);
        stream(8'h10, 16);
        check("sb_full2", 32'(bank_full), 32'b01);
        wait_vld();
        check("sb_bank1", 32'(sync_bank), 32'd0);
        handshake();
        read_chk(5, 8'h15);
        release_pulse();
`endif

        // Reset in the middle of a frame discards it.
        stream(8'h80, 8);
        rst = 1'b1;
        #1;
        check("mid_tready", 32'(act_tready), 32'd0);
        check("mid_vld", 32'(sync_vld), 32'd0);
        check("mid_bank", 32'(sync_bank), 32'd0);
        check("mid_rd_q", 32'(rd_q), 32'd0);
        check("mid_full", 32'(bank_full), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_tready", 32'(act_tready), 32'd1);
        stream(8'h90, 16);
        check("fresh_full", 32'(bank_full), 32'b01);
        wait_vld();
        check("fresh_bank", 32'(sync_bank), 32'd0);
        handshake();
        read_chk(0, 8'h90);
        read_chk(7, 8'h97);
        release_pulse();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
